tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_tx_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// tx_scheduler: two-port round-robin scheduler that feeds packet headers to
// a single transmitter. Port 0 carries connection-FSM packets and port 1
// the ACK-only responder's packets.
// Optional watchdog on the BUSY state: define TX_SCHEDULER_TIMEOUT_EN.
module tx_scheduler #(
    parameter logic [19:0] TIMEOUT = 20'd650000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [31:0] seq0,
    input  logic [31:0] ack0,
    input  logic [8:0]  flags0,
    input  logic        req1,
    input  logic [31:0] seq1,
    input  logic [31:0] ack1,
    input  logic [8:0]  flags1,
    output logic        tx_start,
    output logic [31:0] tx_seq,
    output logic [31:0] tx_ack,
    output logic [8:0]  tx_flags,
    input  logic        tx_done,
    output logic        sent0,
    output logic        sent1,
    output logic        grant_id,
    output logic        tx_timeout,
    output logic        overwrite,
    output logic [1:0]  statedisplay
);

    // Handshake: every control signal is a single-cycle pulse. A req pulse
    // hands over its header at that edge (no back-pressure; a newer req
    // replaces an ungranted one). tx_start offers the header held on tx_*,
    // and tx_done closes it; tx_done is only meaningful while BUSY.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        pend0;
    logic        pend1;
    logic [31:0] buf_seq0;
    logic [31:0] buf_ack0;
    logic [8:0]  buf_flags0;
    logic [31:0] buf_seq1;
    logic [31:0] buf_ack1;
    logic [8:0]  buf_flags1;

    logic        start_grant;
    logic        winner;
    logic        clr0;
    logic        clr1;
    logic        done_ev;
    logic        timeout_ev;

    // Arbitration: the non-owner wins a tie, otherwise whoever is pending.
    always_comb begin
        start_grant = (state == IDLE) && (pend0 || pend1);
        winner      = (pend0 && pend1) ? ~grant_id : pend1;
        clr0        = start_grant && !winner;
        clr1        = start_grant && winner;
        done_ev     = (state == BUSY) && tx_done;
    end

`ifdef TX_SCHEDULER_TIMEOUT_EN
    logic [19:0] watchdog;

    assign timeout_ev = (state == BUSY) && !tx_done && (watchdog == TIMEOUT - 20'd1);

    // Watchdog counts BUSY cycles; cleared on the LOAD->BUSY transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            watchdog   <= 20'd0;
            tx_timeout <= 1'b0;
        end else begin
            tx_timeout <= timeout_ev;
            if (state == LOAD) begin
                watchdog <= 20'd0;
            end else if (state == BUSY) begin
                watchdog <= watchdog + 20'd1;
            end
        end
    end
`else
    // Without the watchdog BUSY waits for tx_done forever; TIMEOUT is
    // referenced only so the parameter stays part of the interface.
    assign timeout_ev = 1'b0;
    assign tx_timeout = 1'b0 & (TIMEOUT != 20'd0);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_grant) state_next = LOAD;
            LOAD:    state_next = BUSY;
            BUSY:    if (done_ev || timeout_ev) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign tx_start     = (state == LOAD);
    assign statedisplay = state;

    // Pending bits and header buffers; a new req beats a same-edge clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            buf_seq0   <= 32'd0;
            buf_ack0   <= 32'd0;
            buf_flags0 <= 9'd0;
            buf_seq1   <= 32'd0;
            buf_ack1   <= 32'd0;
            buf_flags1 <= 9'd0;
            overwrite  <= 1'b0;
        end else begin
            pend0     <= req0 || (pend0 && !clr0);
            pend1     <= req1 || (pend1 && !clr1);
            overwrite <= (req0 && pend0 && !clr0) || (req1 && pend1 && !clr1);
            if (req0) begin
                buf_seq0   <= seq0;
                buf_ack0   <= ack0;
                buf_flags0 <= flags0;
            end
            if (req1) begin
                buf_seq1   <= seq1;
                buf_ack1   <= ack1;
                buf_flags1 <= flags1;
            end
        end
    end

    // Grant bookkeeping: latch the winner's header and report completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_seq   <= 32'd0;
            tx_ack   <= 32'd0;
            tx_flags <= 9'd0;
            grant_id <= 1'b1;
            sent0    <= 1'b0;
            sent1    <= 1'b0;
        end else begin
            sent0 <= done_ev && !grant_id;
            sent1 <= done_ev && grant_id;
            if (start_grant) begin
                grant_id <= winner;
                tx_seq   <= winner ? buf_seq1   : buf_seq0;
                tx_ack   <= winner ? buf_ack1   : buf_ack0;
                tx_flags <= winner ? buf_flags1 : buf_flags0;
            end
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: directed scenarios followed by a
// randomized phase scored against a transaction-level port model.
module tb_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0;
    logic [31:0] seq0 = '0;
    logic [31:0] ack0 = '0;
    logic [8:0]  flags0 = '0;
    logic        req1 = 1'b0;
    logic [31:0] seq1 = '0;
    logic [31:0] ack1 = '0;
    logic [8:0]  flags1 = '0;
    logic        tx_start;
    logic [31:0] tx_seq;
    logic [31:0] tx_ack;
    logic [8:0]  tx_flags;
    logic        tx_done = 1'b0;
    logic        sent0;
    logic        sent1;
    logic        grant_id;
    logic        tx_timeout;
    logic        overwrite;
    logic [1:0]  statedisplay;

    int tests = 0;
    int fails = 0;

    // Port model: latest header per port plus pending flag and last winner.
    bit          m_pend [2];
    logic [31:0] m_seq [2];
    logic [31:0] m_ack [2];
    logic [8:0]  m_flg [2];
    int          m_last;
    logic [0:0]  exp_q [$];

    tx_scheduler #(
`ifdef TX_SCHEDULER_TIMEOUT_EN
        .TIMEOUT(20'd16)
`else
        .TIMEOUT(20'd650000)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .seq0(seq0), .ack0(ack0), .flags0(flags0),
        .req1(req1), .seq1(seq1), .ack1(ack1), .flags1(flags1),
        .tx_start(tx_start), .tx_seq(tx_seq), .tx_ack(tx_ack), .tx_flags(tx_flags),
        .tx_done(tx_done), .sent0(sent0), .sent1(sent1), .grant_id(grant_id),
        .tx_timeout(tx_timeout), .overwrite(overwrite), .statedisplay(statedisplay)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(statedisplay), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_seq"}, tx_seq, 32'd0);
        check({tag, "_tx_ack"}, tx_ack, 32'd0);
        check({tag, "_tx_flags"}, 32'(tx_flags), 32'd0);
        check({tag, "_sent"}, 32'({sent1, sent0}), 32'd0);
        check({tag, "_timeout"}, 32'(tx_timeout), 32'd0);
        check({tag, "_overwrite"}, 32'(overwrite), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd1);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);
        m_pend[0] = 0;
        m_pend[1] = 0;
        m_last = 1;
    endtask

    task automatic pulse_req(input int p, input logic [31:0] s, input logic [31:0] a,
                             input logic [8:0] f);
        if (p == 0) begin
            req0 = 1'b1; seq0 = s; ack0 = a; flags0 = f;
        end else begin
            req1 = 1'b1; seq1 = s; ack1 = a; flags1 = f;
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic expect_grant(input int p, input logic [31:0] s, input logic [31:0] a,
                                input logic [8:0] f);
        wait_start();
        check("grant_port", 32'(grant_id), 32'(p));
        check("tx_seq", tx_seq, s);
        check("tx_ack", tx_ack, a);
        check("tx_flags", 32'(tx_flags), 32'(f));
        check("state_load", 32'(statedisplay), 32'd1);
        @(negedge clk);
        check("tx_start_single", 32'(tx_start), 32'd0);
        check("state_busy", 32'(statedisplay), 32'd2);
    endtask

    task automatic finish_tx(input int p);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("sent0", 32'(sent0), 32'(p == 0));
        check("sent1", 32'(sent1), 32'(p == 1));
        check("state_idle", 32'(statedisplay), 32'd0);
    endtask

    // Model side of a request: returns whether the DUT should flag overwrite.
    function automatic bit model_req(input int p, input logic [31:0] s, input logic [31:0] a,
                                     input logic [8:0] f);
        bit ov;
        ov = m_pend[p];
        m_pend[p] = 1;
        m_seq[p] = s;
        m_ack[p] = a;
        m_flg[p] = f;
        return ov;
    endfunction

    function automatic int model_winner();
        if (m_pend[0] && m_pend[1]) return 1 - m_last;
        return m_pend[0] ? 0 : 1;
    endfunction

    initial begin
        logic [31:0] s;
        logic [31:0] a;
        logic [8:0]  f;
        logic [31:0] s2;
        int p;
        int w;
        bit ov;

        @(negedge clk);
        apply_reset();

        // Contention: four simultaneous pairs, port 0 first every time.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            s = $urandom;
            req0 = 1'b1; seq0 = s; ack0 = ~s; flags0 = 9'h001;
            req1 = 1'b1; seq1 = s + 1; ack1 = s; flags1 = 9'h010;
            @(negedge clk);
            req0 = 1'b0;
            req1 = 1'b0;
            for (int j = 0; j < 2; j++) begin
                w = int'(exp_q.pop_front());
                if (w == 0) expect_grant(0, s, ~s, 9'h001);
                else        expect_grant(1, s + 1, s, 9'h010);
                finish_tx(w);
            end
        end

        // Single request: tx_start two edges after the req edge.
        pulse_req(0, 32'h100, 32'h5, 9'h010);
        check("latency_not_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("latency_start", 32'(tx_start), 32'd1);
        expect_grant(0, 32'h100, 32'h5, 9'h010);
        finish_tx(0);
        @(negedge clk);
        check("sent0_one_cycle", 32'(sent0), 32'd0);

        // Overwrite while port 0 is busy: port 1 sends the latest header.
        pulse_req(0, 32'h200, 32'h6, 9'h002);
        expect_grant(0, 32'h200, 32'h6, 9'h002);
        pulse_req(1, 32'd7, 32'h70, 9'h004);
        check("overwrite_first", 32'(overwrite), 32'd0);
        pulse_req(1, 32'd9, 32'h90, 9'h008);
        check("overwrite_pulse", 32'(overwrite), 32'd1);
        @(negedge clk);
        check("overwrite_one_cycle", 32'(overwrite), 32'd0);
        finish_tx(0);
        expect_grant(1, 32'd9, 32'h90, 9'h008);
        finish_tx(1);

        // Same-edge set/clear: old header goes out, new header follows.
        pulse_req(0, 32'hAAAA, 32'h1, 9'h011);
        pulse_req(0, 32'hBBBB, 32'h2, 9'h022);
        check("same_edge_no_overwrite", 32'(overwrite), 32'd0);
        expect_grant(0, 32'hAAAA, 32'h1, 9'h011);
        finish_tx(0);
        expect_grant(0, 32'hBBBB, 32'h2, 9'h022);
        finish_tx(0);

        // Randomized phase against the port model.
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            if (!m_pend[0] && !m_pend[1]) begin
                p = int'($urandom_range(0, 1));
                s = $urandom; a = $urandom; f = 9'($urandom_range(0, 511));
                ov = model_req(p, s, a, f);
                pulse_req(p, s, a, f);
                check("rand_idle_overwrite", 32'(overwrite), 32'(ov));
            end
            w = model_winner();
            expect_grant(w, m_seq[w], m_ack[w], m_flg[w]);
            m_pend[w] = 0;
            m_last = w;
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
                if ($urandom_range(0, 1) == 1) @(negedge clk);
                p = int'($urandom_range(0, 1));
                s2 = $urandom; a = $urandom; f = 9'($urandom_range(0, 511));
                ov = model_req(p, s2, a, f);
                pulse_req(p, s2, a, f);
                check("rand_overwrite", 32'(overwrite), 32'(ov));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_tx(w);
        end
        // Drain anything the model still holds.
        for (int k = 0; k < 2; k++) begin
            if (m_pend[0] || m_pend[1]) begin
                w = model_winner();
                expect_grant(w, m_seq[w], m_ack[w], m_flg[w]);
                m_pend[w] = 0;
                m_last = w;
                finish_tx(w);
            end
        end

        // Reset in the middle of BUSY abandons the grant silently.
        pulse_req(1, 32'h1234, 32'h5678, 9'h1FF);
        expect_grant(1, 32'h1234, 32'h5678, 9'h1FF);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("midbusy_reset");
        reset_n = 1'b1;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("post_reset_sent", 32'({sent1, sent0}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle", 32'({tx_start, statedisplay}), 32'd0);
        end

        // Watchdog behaviour, or its absence in the default build.
        pulse_req(0, 32'hCAFE, 32'hF00D, 9'h100);
        expect_grant(0, 32'hCAFE, 32'hF00D, 9'h100);
`ifdef TX_SCHEDULER_TIMEOUT_EN
        w = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tx_timeout === 1'b1) begin
                w = i;
                break;
            end
        end
        check("timeout_cycles", 32'(w), 32'd16);
        check("timeout_state", 32'(statedisplay), 32'd0);
        check("timeout_no_sent", 32'({sent1, sent0}), 32'd0);
        @(negedge clk);
        check("timeout_one_cycle", 32'(tx_timeout), 32'd0);
`else
        repeat (40) begin
            @(negedge clk);
            check("no_watchdog_timeout", 32'(tx_timeout), 32'd0);
        end
        check("no_watchdog_busy", 32'(statedisplay), 32'd2);
        finish_tx(0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
